// File: rtl/rf_wb_pkg.sv
// Shared defaults and helpers for the register-file write-back arbiter.
// Build with RF_WB_RR_EN defined for round-robin; default build is fixed priority.
package rf_wb_pkg;

   localparam int RF_NREQ = 3;
   localparam int RF_DW   = 32;
   localparam int RF_AW   = 5;

   // Pointer width for a requester count; one bit minimum so a single requester still elaborates.
   function automatic int ptr_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int          RF_PTR_W     = ptr_width(RF_NREQ);
   localparam logic [15:0] ZERO_CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/rf_wb_rr_pick.sv
// Rotate-priority picker: grants the first valid index after ptr, wrapping.
// A constant ptr of NREQ-1 turns it into a lowest-index-first picker.
module rf_wb_rr_pick
   import rf_wb_pkg::*;
#(
   parameter int NREQ = RF_NREQ,
   parameter int PW   = RF_PTR_W
) (
   input  logic [NREQ-1:0] valid,
   input  logic [PW-1:0]   ptr,
   output logic [NREQ-1:0] grant,
   output logic [PW-1:0]   idx
);

   logic found;
   int   cand;

   // NOTE: every output of this always_comb is given a default first, so no path leaves a latch.
   always_comb begin
      grant = '0;
      idx   = '0;
      found = 1'b0;
      cand  = 0;
      for (int k = 1; k <= NREQ; k++) begin
         cand = (int'(ptr) + k) % NREQ;
         if (!found && valid[cand]) begin
            found       = 1'b1;
            grant[cand] = 1'b1;
            idx         = PW'(cand);
         end
      end
   end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates NREQ write-back requesters onto one register-file write port with a one-cycle stage.
// RF_WB_RR_EN selects round-robin; otherwise lowest valid index always wins.
module regfile_wb_arbiter
   import rf_wb_pkg::*;
#(
   parameter int NREQ = RF_NREQ,
   parameter int DW   = RF_DW,
   parameter int AW   = RF_AW
) (
   input  logic                 Clock,
   input  logic                 Resetn,
   input  logic [NREQ-1:0]      req_valid,
   input  logic [NREQ*AW-1:0]   req_addr,
   input  logic [NREQ*DW-1:0]   req_data,
   output logic [NREQ-1:0]      req_ready,
   input  logic                 hold,
   output logic [AW-1:0]        WriteReg,
   output logic [DW-1:0]        WriteData,
   output logic                 Reg_write_Control,
   output logic [15:0]          zero_drop_count
);

   localparam int            PW        = ptr_width(NREQ);
   localparam logic [PW-1:0] PTR_RESET = PW'(NREQ - 1);

   logic [NREQ-1:0] cand_valid;
   logic [NREQ-1:0] grant;
   logic [PW-1:0]   grant_idx;
   logic [PW-1:0]   ptr;
   logic            accept;
   logic [AW-1:0]   sel_addr;
   logic [DW-1:0]   sel_data;
   logic            sel_zero;
   logic            wr_en_q;

   // Reset and hold both suppress new grants without touching the output stage.
   assign cand_valid = (Resetn && !hold) ? req_valid : '0;

`ifdef RF_WB_RR_EN
   always_ff @(posedge Clock) begin
      if (!Resetn)
         ptr <= PTR_RESET;
      else if (accept)
         ptr <= grant_idx;
   end
`else
   assign ptr = PTR_RESET;
`endif

   rf_wb_rr_pick #(
      .NREQ (NREQ),
      .PW   (PW)
   ) u_pick (
      .valid (cand_valid),
      .ptr   (ptr),
      .grant (grant),
      .idx   (grant_idx)
   );

   assign req_ready = grant;
   assign accept    = |grant;
   assign sel_addr  = req_addr[grant_idx*AW +: AW];
   assign sel_data  = req_data[grant_idx*DW +: DW];
   assign sel_zero  = (sel_addr == '0);

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge Clock) begin
      if (!Resetn) begin
         wr_en_q         <= 1'b0;
         WriteReg        <= '0;
         WriteData       <= '0;
         zero_drop_count <= '0;
      end else begin
         wr_en_q <= accept && !sel_zero;
         if (accept && !sel_zero) begin
            WriteReg  <= sel_addr;
            WriteData <= sel_data;
         end
         if (accept && sel_zero && (zero_drop_count != ZERO_CNT_MAX))
            zero_drop_count <= zero_drop_count + 16'd1;
      end
   end

   // A staged write is discarded in the very cycle reset is sampled, not just after it.
   assign Reg_write_Control = wr_en_q & Resetn;

   a_ready_onehot0 : assert property (@(posedge Clock) $onehot0(req_ready));

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench: directed scenarios with literal expectations plus a random run against a reference model.
// Follows RF_WB_RR_EN the same way the design does.
module tb_regfile_wb_arbiter;

   localparam int NREQ = 3;
   localparam int DW   = 32;
   localparam int AW   = 5;
`ifdef RF_WB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic              Clock = 1'b0;
   logic              Resetn = 1'b0;
   logic              hold = 1'b0;
   logic [NREQ-1:0]   req_valid = '0;
   logic [NREQ*AW-1:0] req_addr = '0;
   logic [NREQ*DW-1:0] req_data = '0;
   logic [NREQ-1:0]   req_ready;
   logic [AW-1:0]     WriteReg;
   logic [DW-1:0]     WriteData;
   logic              Reg_write_Control;
   logic [15:0]       zero_drop_count;

   int tests = 0;
   int fails = 0;

   always #5 Clock = ~Clock;

   regfile_wb_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
      .Clock             (Clock),
      .Resetn            (Resetn),
      .req_valid         (req_valid),
      .req_addr          (req_addr),
      .req_data          (req_data),
      .req_ready         (req_ready),
      .hold              (hold),
      .WriteReg          (WriteReg),
      .WriteData         (WriteData),
      .Reg_write_Control (Reg_write_Control),
      .zero_drop_count   (zero_drop_count)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s at %0t: actual %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   int              m_ptr = NREQ - 1;
   bit              m_wen = 1'b0;
   logic [AW-1:0]   m_waddr = '0;
   logic [DW-1:0]   m_wdata = '0;
   int              m_cnt = 0;
   logic [NREQ-1:0] m_g;

   // Which requester is served: the first valid one in search order, none under reset or hold.
   function automatic logic [NREQ-1:0] model_grant(input logic [NREQ-1:0] v, input int ptr,
                                                   input bit rst_n, input bit h);
      logic [NREQ-1:0] g;
      int order[$];
      g = '0;
      if (!rst_n || h) return g;
      for (int k = 1; k <= NREQ; k++) order.push_back(RR ? (ptr + k) % NREQ : k - 1);
      foreach (order[j]) begin
         if (v[order[j]]) begin
            g[order[j]] = 1'b1;
            return g;
         end
      end
      return g;
   endfunction

   always @(negedge Clock) begin
      m_g = model_grant(req_valid, m_ptr, Resetn, hold);
      check("req_ready", req_ready, m_g);
      check("write_en", Reg_write_Control, m_wen && Resetn);
      if (m_wen && Resetn) begin
         check("write_reg", WriteReg, m_waddr);
         check("write_data", WriteData, m_wdata);
      end
      check("zero_cnt", zero_drop_count, m_cnt);
      if (!Resetn) begin
         m_wen = 1'b0; m_waddr = '0; m_wdata = '0; m_cnt = 0; m_ptr = NREQ - 1;
      end else begin
         m_wen = 1'b0;
         for (int c = 0; c < NREQ; c++) begin
            if (m_g[c]) begin
               m_ptr = c;
               if (req_addr[c*AW +: AW] == '0) begin
                  if (m_cnt < 65535) m_cnt = m_cnt + 1;
               end else begin
                  m_wen   = 1'b1;
                  m_waddr = req_addr[c*AW +: AW];
                  m_wdata = req_data[c*DW +: DW];
               end
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic set_req(input int i, input bit v, input logic [AW-1:0] a, input logic [DW-1:0] d);
      req_valid[i]       = v;
      req_addr[i*AW +: AW] = a;
      req_data[i*DW +: DW] = d;
   endtask

   task automatic next_cycle();
      @(posedge Clock);
      #1;
   endtask

   task automatic do_reset();
      Resetn = 1'b0;
      hold   = 1'b0;
      next_cycle();
      Resetn = 1'b1;
   endtask

   task automatic all_valid();
      set_req(0, 1'b1, 5'd5, 32'h0000_000A);
      set_req(1, 1'b1, 5'd6, 32'h0000_000B);
      set_req(2, 1'b1, 5'd7, 32'h0000_000C);
   endtask

   logic [DW-1:0]   data_tab [NREQ] = '{32'h0000_000A, 32'h0000_000B, 32'h0000_000C};
   logic [NREQ-1:0] acc;
   int              exp_idx;
   int              prev_idx;

   initial begin
      // Reset with every requester asking.
      all_valid();
      Resetn = 1'b0;
      repeat (2) begin
         @(negedge Clock);
         check("rst_ready", req_ready, 3'b000);
         check("rst_wen", Reg_write_Control, 1'b0);
         check("rst_cnt", zero_drop_count, 16'h0000);
         check("rst_wreg", WriteReg, 5'd0);
         check("rst_wdata", WriteData, 32'h0);
      end
      next_cycle();
      Resetn = 1'b1;

      // Continuous requests on all three.
      prev_idx = 0;
      for (int cyc = 0; cyc < 6; cyc++) begin
         exp_idx = RR ? cyc % 3 : 0;
         @(negedge Clock);
         check("seq_ready", req_ready, 3'b001 << exp_idx);
         check("seq_wen", Reg_write_Control, cyc > 0);
         if (cyc > 0) begin
            check("seq_wreg", WriteReg, 5 + prev_idx);
            check("seq_wdata", WriteData, data_tab[prev_idx]);
         end
         prev_idx = exp_idx;
         next_cycle();
      end

      // Write to register 0 is consumed and counted, never written.
      do_reset();
      req_valid = '0;
      set_req(1, 1'b1, 5'd0, 32'h0000_DEAD);
      @(negedge Clock);
      check("r0_ready", req_ready, 3'b010);
      next_cycle();
      req_valid = '0;
      @(negedge Clock);
      check("r0_wen", Reg_write_Control, 1'b0);
      check("r0_cnt", zero_drop_count, 16'd1);
      next_cycle();

      // Hold does not cancel a staged write and freezes the pointer.
      do_reset();
      all_valid();
      @(negedge Clock);
      check("hold_first", req_ready, 3'b001);
      next_cycle();
      hold = 1'b1;
      @(negedge Clock);
      check("hold_wen", Reg_write_Control, 1'b1);
      check("hold_wreg", WriteReg, 5'd5);
      check("hold_ready", req_ready, 3'b000);
      next_cycle();
      @(negedge Clock);
      check("hold_ready2", req_ready, 3'b000);
      check("hold_wen2", Reg_write_Control, 1'b0);
      next_cycle();
      hold = 1'b0;
      @(negedge Clock);
      check("hold_release", req_ready, RR ? 3'b010 : 3'b001);
      next_cycle();

      // Reset arriving right after an accept discards the staged write.
      do_reset();
      all_valid();
      @(negedge Clock);
      check("mid_g0", req_ready, 3'b001);
      next_cycle();
      @(negedge Clock);
      check("mid_g1", req_ready, RR ? 3'b010 : 3'b001);
      next_cycle();
      Resetn = 1'b0;
      @(negedge Clock);
      check("mid_wen", Reg_write_Control, 1'b0);
      check("mid_ready", req_ready, 3'b000);
      next_cycle();
      Resetn = 1'b1;
      @(negedge Clock);
      check("mid_after", req_ready, 3'b001);
      check("mid_wen2", Reg_write_Control, 1'b0);
      next_cycle();

      // Drop counter saturation: one register-0 write per cycle past the limit.
      do_reset();
      req_valid = '0;
      set_req(0, 1'b1, 5'd0, 32'h1234_5678);
      for (int i = 0; i < 65536; i++) begin
         if (i == 65534) begin
            @(negedge Clock);
            check("sat_fffe", zero_drop_count, 16'hFFFE);
         end
         next_cycle();
      end
      @(negedge Clock);
      check("sat_ffff", zero_drop_count, 16'hFFFF);
      next_cycle();
      @(negedge Clock);
      check("sat_stay", zero_drop_count, 16'hFFFF);
      next_cycle();

      // Random traffic; requesters keep a request stable until it is accepted.
      do_reset();
      req_valid = '0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(negedge Clock);
         acc = req_valid & req_ready;
         next_cycle();
         for (int i = 0; i < NREQ; i++) begin
            if (!req_valid[i] || acc[i])
               set_req(i, $urandom_range(0, 3) != 0,
                       ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                       $urandom);
         end
         hold   = ($urandom_range(0, 3) == 0);
         Resetn = ($urandom_range(0, 63) != 0);
      end
      @(negedge Clock);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameter NREQ, default 3: number of write-back requesters (index 0 = ALU, 1 = load unit, 2 = link/JAL).
REQ-002 Parameter DW, default 32: data width; parameter AW, default 5: register address width.
REQ-003 Clock  input  1  rising-edge clock.
REQ-004 Resetn  input  1  reset, synchronous, active-low.
REQ-005 req_valid  input  NREQ  per-requester write request.
REQ-006 req_addr  input  NREQ*AW  per-requester destination register; slice i = bits [i*AW +: AW].
REQ-007 req_data  input  NREQ*DW  per-requester write data; slice i = bits [i*DW +: DW].
REQ-008 req_ready  output  NREQ  one-hot-or-zero grant; request i accepted in a cycle with req_valid[i] & req_ready[i].
REQ-009 hold  input  1  when 1, no new grants.
REQ-010 WriteReg  output  AW  register-file write address.
REQ-011 WriteData  output  DW  register-file write data.
REQ-012 Reg_write_Control  output  1  register-file write enable.
REQ-013 zero_drop_count  output  16  saturating count of accepted writes to register 0.

Function
REQ-014 req_ready SHALL be combinational from req_valid, hold and the priority pointer; at most one bit set per cycle.
REQ-015 req_ready[i] SHALL be 1 only if req_valid[i]=1, hold=0, Resetn=1, and i is the first valid index found searching from (ptr+1) mod NREQ upward with wrap.
REQ-016 Accepted request SHALL load a one-entry output stage at the next rising edge; WriteReg/WriteData/Reg_write_Control SHALL present it in the following cycle (latency 1, one write per cycle, back-to-back sustained).
REQ-017 Output stage SHALL drain every cycle; cycle with no acceptance SHALL give Reg_write_Control=0 next cycle, with WriteReg/WriteData holding their last values.
REQ-018 Accepted request with address 0 SHALL be consumed (ready=1) but SHALL produce Reg_write_Control=0; zero_drop_count SHALL increment by 1, saturating at 16'hFFFF.
REQ-019 ptr SHALL update to the granted index only on acceptance; otherwise unchanged.
REQ-020 Continuously valid requester SHALL be granted within NREQ cycles of hold=0.
REQ-021 hold=1 SHALL not cancel a write already in the output stage.
REQ-022 Requesters hold valid/addr/data stable until accepted; the arbiter performs no hazard or same-address checks.

Reset
REQ-023 When Resetn=0 at a rising edge: Reg_write_Control<=0, WriteReg<=0, WriteData<=0, zero_drop_count<=0, ptr<=NREQ-1 (index 0 first priority).
REQ-024 While Resetn=0, req_ready SHALL be all zero; a write in the output stage when reset is sampled SHALL be discarded.

Configuration
REQ-025 Macro RF_WB_RR_EN defined: round-robin per REQ-015/REQ-019.
REQ-026 RF_WB_RR_EN undefined: fixed priority, lowest valid index wins; ptr removed; REQ-020 not guaranteed.

Structure
REQ-027 Package rf_wb_pkg SHALL hold NREQ, DW, AW defaults, pointer width localparam and zero-count saturation constant.
REQ-028 Sub-module rf_wb_rr_pick SHALL implement the combinational rotate-priority picker (valid vector, ptr -> one-hot grant, index).

Verification
REQ-029 Reset: Resetn=0 two cycles, all valid=1 -> req_ready=000, Reg_write_Control=0, zero_drop_count=0.
REQ-030 Round-robin: all three valid continuously, addrs 5/6/7, data A/B/C -> grants 0,1,2,0,...; writes (5,A),(6,B),(7,C) on consecutive cycles, each one cycle after grant.
REQ-031 Register 0: req1 valid addr 0 data 32'hDEAD -> ready[1]=1, next cycle Reg_write_Control=0, zero_drop_count=1; preload 16'hFFFE, three drops -> 16'hFFFF.
REQ-032 Hold: grant to req0 at cycle n, hold=1 at n+1 -> write issued at n+1, req_ready=000 while hold=1, ptr unchanged, req1 granted first cycle after release.
REQ-033 Reset mid-stream: Resetn=0 in cycle after accept -> no write issued, ptr=NREQ-1, req0 granted first after release.
REQ-034 Fixed priority build (RF_WB_RR_EN undefined): req0 and req2 continuously valid -> req0 granted every cycle, req2 never.
